// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and encodings for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

   localparam logic [1:0] TUSE_NONE = 2'd3;
   localparam logic [4:0] EPC_REG   = 5'd14;

   localparam int unsigned DEF_MULT_CYC = 5;
   localparam int unsigned DEF_DIV_CYC  = 10;

   // Bit positions of the per-cause stall vector, exposed for debug taps.
   typedef enum logic [1:0] {
      RAW_RS = 2'd0,
      RAW_RT = 2'd1,
      MD     = 2'd2,
      ERET   = 2'd3
   } stall_cause_e;

   localparam int unsigned NUM_CAUSE = 4;

   typedef enum logic {
      MdIdle = 1'b0,
      MdBusy = 1'b1
   } md_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// Multiply/divide occupancy counter: loads on a start pulse, counts down to idle.
module pipe_hazard_ctrl_md_busy_counter
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYC = DEF_MULT_CYC,
   parameter int unsigned DIV_CYC  = DEF_DIV_CYC,
   parameter int unsigned CNT_W    = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   output logic busy,
   output logic done
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   md_state_e        state;

   assign state = (cnt_q != '0) ? MdBusy : MdIdle;

   // A start while busy reloads; the hazard logic normally prevents it.
   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      end else if (state == MdBusy) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy = (state == MdBusy);
   assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline (RAW, MDU occupancy, ERET/EPC).
// Optional PIPE_STALL_CNT_EN adds saturating stall cycle counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYC = DEF_MULT_CYC,
   parameter int unsigned DIV_CYC  = DEF_DIV_CYC,
   parameter int unsigned CNT_W    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] D_rs,
   input  logic [4:0] D_rt,
   input  logic [1:0] D_TuseRs,
   input  logic [1:0] D_TuseRt,
   input  logic       D_isMD,
   input  logic       D_eret,
   input  logic [4:0] E_dst,
   input  logic [4:0] M_dst,
   input  logic       E_RegWrite,
   input  logic       M_RegWrite,
   input  logic [1:0] E_timeNew,
   input  logic [1:0] M_timeNew,
   input  logic       E_mdStart,
   input  logic       E_mdIsDiv,
   input  logic       E_mtcEPC,
   input  logic       M_mtcEPC,
   input  logic       Req,
   output logic       FD_en,
   output logic       DE_clr,
   output logic       flush,
   output logic       md_busy,
   output logic       md_done
`ifdef PIPE_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] md_stall_cnt
`endif
);

   if ((2 ** CNT_W) <= MULT_CYC || (2 ** CNT_W) <= DIV_CYC) begin : g_cnt_w_check
      $error("CNT_W too narrow for MULT_CYC/DIV_CYC");
   end

   logic                 busy_raw, done_raw;
   logic [NUM_CAUSE-1:0] stall_cause;
   logic                 stall;

   pipe_hazard_ctrl_md_busy_counter #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC),
      .CNT_W    (CNT_W)
   ) u_md_cnt (
      .clk    (clk),
      .reset  (reset),
      .start  (E_mdStart & ~Req),
      .is_div (E_mdIsDiv),
      .busy   (busy_raw),
      .done   (done_raw)
   );

   // TUSE_NONE (3) can never be below a 2-bit Tnew, so unused sources never stall.
   always_comb begin
      stall_cause = '0;
      stall_cause[RAW_RS] = (D_rs != 5'd0) &&
         ((E_RegWrite && E_dst == D_rs && D_TuseRs < E_timeNew) ||
          (M_RegWrite && M_dst == D_rs && D_TuseRs < M_timeNew));
      stall_cause[RAW_RT] = (D_rt != 5'd0) &&
         ((E_RegWrite && E_dst == D_rt && D_TuseRt < E_timeNew) ||
          (M_RegWrite && M_dst == D_rt && D_TuseRt < M_timeNew));
      stall_cause[MD]     = D_isMD && (busy_raw || E_mdStart);
      stall_cause[ERET]   = D_eret && (E_mtcEPC || M_mtcEPC);
   end

   assign stall = |stall_cause;

   // Flush overrides stall; everything is held quiet while reset is low.
   always_comb begin
      FD_en   = 1'b1;
      DE_clr  = 1'b0;
      flush   = 1'b0;
      md_busy = 1'b0;
      md_done = 1'b0;
      if (reset) begin
         md_busy = busy_raw;
         md_done = done_raw;
         if (Req) begin
            flush = 1'b1;
         end else begin
            FD_en  = ~stall;
            DE_clr = stall;
         end
      end
   end

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_cnt_q, md_stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt_q    <= '0;
         md_stall_cnt_q <= '0;
      end else begin
         if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (stall_cause[MD] && md_stall_cnt_q != 32'hFFFF_FFFF) begin
            md_stall_cnt_q <= md_stall_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cnt    = stall_cnt_q;
   assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule
